// File: rtl/division_sign_restore_if.sv
// Handshake and data bundle between the division datapath and the sign-restore stage.
// master drives request/magnitudes/signs; slave (the restore block) returns signed results.
interface division_sign_restore_if;
  logic       restore_sel;
  logic [3:0] quotient_mag;
  logic [3:0] remainder_mag;
  logic       first_neg;
  logic       second_neg;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       overflow;
  logic       restore_finish;

  modport master (
    output restore_sel, quotient_mag, remainder_mag, first_neg, second_neg,
    input  quotient, remainder, overflow, restore_finish
  );

  modport slave (
    input  restore_sel, quotient_mag, remainder_mag, first_neg, second_neg,
    output quotient, remainder, overflow, restore_finish
  );
endinterface

// File: rtl/division_sign_restore.sv
// Bit-serial LSB-first negation of quotient/remainder magnitudes; results valid 4 edges after capture,
// finish held until restore_sel drops. DIVISION_SIGN_RESTORE_SAT_EN saturates a +8 quotient to +7.
module division_sign_restore (
  input  logic                   clk,
  input  logic                   rst,
  division_sign_restore_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] q_mag_q, q_mag_d, r_mag_q, r_mag_d;
  logic [3:0] q_acc_q, q_acc_d, r_acc_q, r_acc_d;
  logic       q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic       q_carry_q, q_carry_d, r_carry_q, r_carry_d;
  logic [3:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic       finish_q, finish_d;
  logic       q_bit, r_bit;
  logic [3:0] q_raw, r_raw;
`ifdef DIVISION_SIGN_RESTORE_SAT_EN
  logic       overflow_q, overflow_d;
`endif

  // Current serial bit; the accumulators fill from the MSB so bit 3 lands last.
  always_comb begin
    q_bit = q_neg_q ? (~q_mag_q[0] ^ q_carry_q) : q_mag_q[0];
    r_bit = r_neg_q ? (~r_mag_q[0] ^ r_carry_q) : r_mag_q[0];
    q_raw = {q_bit, q_acc_q[3:1]};
    r_raw = {r_bit, r_acc_q[3:1]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_mag_d     = q_mag_q;
    r_mag_d     = r_mag_q;
    q_acc_d     = q_acc_q;
    r_acc_d     = r_acc_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    q_carry_d   = q_carry_q;
    r_carry_d   = r_carry_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    finish_d    = finish_q;
`ifdef DIVISION_SIGN_RESTORE_SAT_EN
    overflow_d  = overflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.restore_sel) begin
          state_d   = CONV;
          cnt_d     = 2'd0;
          q_mag_d   = bus.quotient_mag;
          r_mag_d   = bus.remainder_mag;
          q_neg_d   = bus.first_neg ^ bus.second_neg;
          r_neg_d   = bus.first_neg;
          q_carry_d = 1'b1;
          r_carry_d = 1'b1;
        end
      end
      CONV: begin
        q_mag_d   = q_mag_q >> 1;
        r_mag_d   = r_mag_q >> 1;
        q_acc_d   = q_raw;
        r_acc_d   = r_raw;
        q_carry_d = ~q_mag_q[0] & q_carry_q;
        r_carry_d = ~r_mag_q[0] & r_carry_q;
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d     = DONE;
          finish_d    = 1'b1;
          remainder_d = r_raw;
`ifdef DIVISION_SIGN_RESTORE_SAT_EN
          // Only a positive magnitude of 8 serialises to 4'b1000; negative 8 is the valid -8.
          if (!q_neg_q && q_raw == 4'b1000) begin
            quotient_d = 4'b0111;
            overflow_d = 1'b1;
          end else begin
            quotient_d = q_raw;
            overflow_d = 1'b0;
          end
`else
          quotient_d  = q_raw;
`endif
        end
      end
      DONE: begin
        if (!bus.restore_sel) begin
          state_d  = IDLE;
          finish_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      q_mag_q     <= 4'd0;
      r_mag_q     <= 4'd0;
      q_acc_q     <= 4'd0;
      r_acc_q     <= 4'd0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      q_carry_q   <= 1'b0;
      r_carry_q   <= 1'b0;
      quotient_q  <= 4'd0;
      remainder_q <= 4'd0;
      finish_q    <= 1'b0;
`ifdef DIVISION_SIGN_RESTORE_SAT_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_mag_q     <= q_mag_d;
      r_mag_q     <= r_mag_d;
      q_acc_q     <= q_acc_d;
      r_acc_q     <= r_acc_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      q_carry_q   <= q_carry_d;
      r_carry_q   <= r_carry_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      finish_q    <= finish_d;
`ifdef DIVISION_SIGN_RESTORE_SAT_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign bus.quotient       = quotient_q;
  assign bus.remainder      = remainder_q;
  assign bus.restore_finish = finish_q;
`ifdef DIVISION_SIGN_RESTORE_SAT_EN
  assign bus.overflow       = overflow_q;
`else
  assign bus.overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_division_sign_restore.sv
// Directed plus randomized checks of division_sign_restore against a signed-arithmetic reference.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_division_sign_restore;

  logic clk;
  logic rst;
  int   nchk;
  int   nerr;

  division_sign_restore_if bus ();

  division_sign_restore dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: signed value from sign rules, then 4-bit wrap or saturation.
  function automatic logic [3:0] ref_quot(input int qm, input bit fn, input bit sn);
    int v;
    v = (fn ^ sn) ? -qm : qm;
`ifdef DIVISION_SIGN_RESTORE_SAT_EN
    if (v > 7) v = 7;
`endif
    return 4'(v);
  endfunction

  function automatic logic [3:0] ref_ovf(input int qm, input bit fn, input bit sn);
`ifdef DIVISION_SIGN_RESTORE_SAT_EN
    return {3'b000, (!(fn ^ sn) && qm == 8)};
`else
    if (qm < 0 || fn || sn) return 4'd0;
    return 4'd0;
`endif
  endfunction

  function automatic logic [3:0] ref_rem(input int rm, input bit fn);
    int v;
    v = fn ? -rm : rm;
    return 4'(v);
  endfunction

  task automatic drive(input int qm, input int rm, input bit fn, input bit sn);
    bus.quotient_mag  = 4'(qm);
    bus.remainder_mag = 4'(rm);
    bus.first_neg     = fn;
    bus.second_neg    = sn;
  endtask

  // One full transaction: capture, 4 CONV edges, then one DONE edge back to IDLE.
  task automatic conv(input int qm, input int rm, input bit fn, input bit sn, input bit scramble);
    drive(qm, rm, fn, sn);
    bus.restore_sel = 1'b1;
    tick();
    bus.restore_sel = 1'b0;
    if (scramble) drive($urandom_range(8), $urandom_range(7), 1'($urandom), 1'($urandom));
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("finish_early", {3'b000, bus.restore_finish}, 4'd0);
    end
    tick();
    check("finish_n4", {3'b000, bus.restore_finish}, 4'd1);
    check("quotient", bus.quotient, ref_quot(qm, fn, sn));
    check("remainder", bus.remainder, ref_rem(rm, fn));
    check("overflow", {3'b000, bus.overflow}, ref_ovf(qm, fn, sn));
    tick();
    check("finish_drop", {3'b000, bus.restore_finish}, 4'd0);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst  = 1'b1;
    bus.restore_sel = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_quotient", bus.quotient, 4'd0);
    check("rst_remainder", bus.remainder, 4'd0);
    check("rst_overflow", {3'b000, bus.overflow}, 4'd0);
    check("rst_finish", {3'b000, bus.restore_finish}, 4'd0);

    // -7 / 2
    conv(3, 1, 1'b1, 1'b0, 1'b0);
    check("m7d2_q_lit", bus.quotient, 4'b1101);
    check("m7d2_r_lit", bus.remainder, 4'b1111);
    // -6 / -2
    conv(3, 0, 1'b1, 1'b1, 1'b0);
    check("m6dm2_q_lit", bus.quotient, 4'b0011);
    // -8 / -1
    conv(8, 0, 1'b1, 1'b1, 1'b0);
    // -8 / 1 : negative magnitude 8 is representable
    conv(8, 0, 1'b1, 1'b0, 1'b0);
    check("neg8_q_lit", bus.quotient, 4'b1000);
    // negative zero magnitudes
    conv(0, 0, 1'b1, 1'b0, 1'b0);
    conv(7, 7, 1'b0, 1'b0, 1'b0);

    // Captured values win over inputs changed during CONV.
    drive(2, 1, 1'b1, 1'b0);
    bus.restore_sel = 1'b1;
    tick();
    bus.restore_sel = 1'b0;
    drive(5, 3, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    check("ign_finish_pre", {3'b000, bus.restore_finish}, 4'd0);
    tick();
    check("ign_finish", {3'b000, bus.restore_finish}, 4'd1);
    check("ign_quotient", bus.quotient, 4'b1110);
    check("ign_remainder", bus.remainder, 4'b1111);
    tick();

    // Reset during CONV at edge N+2.
    drive(5, 2, 1'b0, 1'b1);
    bus.restore_sel = 1'b1;
    tick();
    bus.restore_sel = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstc_quotient", bus.quotient, 4'd0);
    check("rstc_remainder", bus.remainder, 4'd0);
    check("rstc_overflow", {3'b000, bus.overflow}, 4'd0);
    check("rstc_finish", {3'b000, bus.restore_finish}, 4'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("rstc_no_finish", {3'b000, bus.restore_finish}, 4'd0);
    end

    // restore_sel held high for 10 edges: a single conversion.
    drive(4, 3, 1'b0, 1'b1);
    bus.restore_sel = 1'b1;
    tick();
    drive(1, 1, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("hold_finish", {3'b000, bus.restore_finish}, (k >= 4) ? 4'd1 : 4'd0);
      if (k >= 4) check("hold_quotient", bus.quotient, 4'b1100);
    end
    check("hold_remainder", bus.remainder, 4'b0011);
    bus.restore_sel = 1'b0;
    tick();
    check("hold_drop", {3'b000, bus.restore_finish}, 4'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_no_retrig", {3'b000, bus.restore_finish}, 4'd0);
    end
    check("hold_q_kept", bus.quotient, 4'b1100);

    // Reset during DONE.
    drive(6, 5, 1'b1, 1'b0);
    bus.restore_sel = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("rstd_finish_pre", {3'b000, bus.restore_finish}, 4'd1);
    check("rstd_quotient_pre", bus.quotient, 4'b1010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.restore_sel = 1'b0;
    check("rstd_finish", {3'b000, bus.restore_finish}, 4'd0);
    check("rstd_quotient", bus.quotient, 4'd0);
    check("rstd_remainder", bus.remainder, 4'd0);
    tick();

    // Randomized conversions, half of them with inputs disturbed during CONV.
    for (int i = 0; i < 40; i++) begin
      conv($urandom_range(8), $urandom_range(7), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
